mor1kx_ctrl_except_cappuccino: RTL and testbench

Control-stage exception and special-register unit for the cappuccino pipeline. It sits directly downstream of the execute-to-control pipeline register. It consumes the registered per-instruction exception flags, PC, ALU result and flag set/clear, and on an exception or `l.rfe` it:
- saves EPCR, EEAR and ESR and updates SR,
- flushes the pipeline,
- redirects fetch to the handler or the return address.

---
 rtl/mor1kx_ctrl_except_cappuccino.sv | 183 ++++++++++++++++++
 tb/tb_mor1kx_ctrl_except_cappuccino.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_ctrl_except_cappuccino.sv
// mor1kx_ctrl_except_cappuccino
// Control-stage exception / special-register unit for the cappuccino pipeline.
// It consumes the registered exception flags, PC, ALU result and flag requests
// of the instruction in the ctrl stage. On an exception or l.rfe it:
//   - saves EPCR/EEAR/ESR and updates SR,
//   - pulses a pipeline flush,
//   - then requests a fetch redirect until fetch acknowledges it.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ctrl_advance_i            ctrl instruction retires this cycle
//   ctrl_except_*_i           registered exception flags
//   ctrl_op_rfe_i             ctrl instruction is l.rfe
//   pc_ctrl_i                 PC of ctrl instruction
//   ctrl_alu_result_i         load/store effective address
//   ctrl_flag_set_i/clear_i   SR[F] update request
//   spr_we_i/addr_i/dat_i     SPR write port (SR, EPCR, EEAR, ESR)
//   fetch_redirect_ack_i      fetch accepted the redirect
//   pipeline_flush_o          one-cycle flush pulse
//   ctrl_stall_o              hold upstream stages
//   redirect_o/redirect_pc_o  fetch redirect request and target
//   spr_sr_o/epcr_o/eear_o/esr_o, flag_o  architectural state
module mor1kx_ctrl_except_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC = {19'b0, 5'h01, 8'h00}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ctrl_advance_i,
  input  logic                            ctrl_except_ibus_err_i,
  input  logic                            ctrl_except_ibus_align_i,
  input  logic                            ctrl_except_illegal_i,
  input  logic                            ctrl_except_syscall_i,
  input  logic                            ctrl_except_trap_i,
  input  logic                            ctrl_except_dbus_i,
  input  logic                            ctrl_except_align_i,
  input  logic                            ctrl_op_rfe_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_ctrl_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
  input  logic                            ctrl_flag_set_i,
  input  logic                            ctrl_flag_clear_i,
  input  logic                            spr_we_i,
  input  logic [15:0]                     spr_addr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dat_i,
  input  logic                            fetch_redirect_ack_i,
  output logic                            pipeline_flush_o,
  output logic                            ctrl_stall_o,
  output logic                            redirect_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic [15:0]                     spr_sr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_epcr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_eear_o,
  output logic [15:0]                     spr_esr_o,
  output logic                            flag_o
);

  localparam int W = OPTION_OPERAND_WIDTH;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_WAIT} state_t;

  state_t         state_reg, state_next;
  logic [15:0]    sr_reg, sr_next;
  logic [15:0]    esr_reg, esr_next;
  logic [W-1:0]   epcr_reg, epcr_next;
  logic [W-1:0]   eear_reg, eear_next;
  logic [W-1:0]   target_reg, target_next;

  logic           in_run, any_exc, exc_event, rfe_event, insn_event;
  logic [11:0]    vector;
  logic [W-1:0]   exc_epcr, exc_eear;

  assign in_run  = (state_reg == ST_RUN);
  assign any_exc = ctrl_except_ibus_err_i | ctrl_except_ibus_align_i |
                   ctrl_except_illegal_i  | ctrl_except_syscall_i    |
                   ctrl_except_trap_i     | ctrl_except_dbus_i       |
                   ctrl_except_align_i;
  // An exception on the same instruction masks the RFE.
  assign exc_event  = in_run & ctrl_advance_i & any_exc;
  assign rfe_event  = in_run & ctrl_advance_i & ctrl_op_rfe_i & ~any_exc;
  assign insn_event = exc_event | rfe_event;

  // Priority encoder: vector and saved addresses of the winning exception.
  always_comb begin
    vector   = 12'h000;
    exc_epcr = pc_ctrl_i;
    exc_eear = pc_ctrl_i;
    if (ctrl_except_ibus_err_i)        vector = 12'h200;
    else if (ctrl_except_ibus_align_i) vector = 12'h600;
    else if (ctrl_except_illegal_i)    vector = 12'h700;
    else if (ctrl_except_syscall_i) begin
      vector   = 12'hC00;
      // syscall returns past itself
      exc_epcr = pc_ctrl_i + W'(4);
    end
    else if (ctrl_except_trap_i)       vector = 12'hE00;
    else if (ctrl_except_dbus_i) begin
      vector   = 12'h200;
      exc_eear = ctrl_alu_result_i;
    end
    else if (ctrl_except_align_i) begin
      vector   = 12'h600;
      exc_eear = ctrl_alu_result_i;
    end
  end

  // Special-register and redirect-target next values.
  always_comb begin
    sr_next     = sr_reg;
    esr_next    = esr_reg;
    epcr_next   = epcr_reg;
    eear_next   = eear_reg;
    target_next = target_reg;
    if (exc_event) begin
      esr_next    = sr_reg;
      sr_next     = {sr_reg[15:3], 3'b001};   // SM=1, TEE=0, IEE=0
      epcr_next   = exc_epcr;
      eear_next   = exc_eear;
      target_next = {{(W-12){1'b0}}, vector};
    end else if (rfe_event) begin
      sr_next     = esr_reg | 16'h8000;
      target_next = epcr_reg;
    end else begin
      if (spr_we_i) begin
        case (spr_addr_i)
          16'h0011: sr_next   = spr_dat_i[15:0] | 16'h8000;
          16'h0020: epcr_next = spr_dat_i;
          16'h0030: eear_next = spr_dat_i;
          16'h0040: esr_next  = spr_dat_i[15:0];
          default: ;
        endcase
      end
      // Flag requests apply on top of any SR write; set beats clear.
      if (in_run & ctrl_advance_i) begin
        if (ctrl_flag_set_i)        sr_next[9] = 1'b1;
        else if (ctrl_flag_clear_i) sr_next[9] = 1'b0;
      end
    end
  end

  // State register plus architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      sr_reg     <= 16'h8001;
      esr_reg    <= 16'h0000;
      epcr_reg   <= OPTION_RESET_PC;
      eear_reg   <= OPTION_RESET_PC;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sr_reg     <= sr_next;
      esr_reg    <= esr_next;
      epcr_reg   <= epcr_next;
      eear_reg   <= eear_next;
      target_reg <= target_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (insn_event) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_WAIT;
      ST_WAIT:  if (fetch_redirect_ack_i) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    pipeline_flush_o = (state_reg == ST_FLUSH);
    redirect_o       = (state_reg == ST_WAIT);
    ctrl_stall_o     = (state_reg == ST_FLUSH) | (state_reg == ST_WAIT);
  end

  assign redirect_pc_o = target_reg;
  assign spr_sr_o      = sr_reg;
  assign spr_esr_o     = esr_reg;
  assign spr_epcr_o    = epcr_reg;
  assign spr_eear_o    = eear_reg;
  assign flag_o        = sr_reg[9];

endmodule

// File: tb/tb_mor1kx_ctrl_except_cappuccino.sv
// Self-checking bench for mor1kx_ctrl_except_cappuccino. Expected exception
// results are queued when an event is driven and compared once the DUT raises
// its redirect request.
module tb_mor1kx_ctrl_except_cappuccino;

  logic        clk = 1'b0;
  logic        rst;
  logic        advance;
  logic        ibus_err, ibus_align, illegal, syscall, trap, dbus, align;
  logic        rfe;
  logic [31:0] pc_ctrl, alu_result;
  logic        flag_set, flag_clear;
  logic        spr_we;
  logic [15:0] spr_addr;
  logic [31:0] spr_dat;
  logic        ack;
  logic        pipeline_flush, ctrl_stall, redirect;
  logic [31:0] redirect_pc;
  logic [15:0] spr_sr, spr_esr;
  logic [31:0] spr_epcr, spr_eear;
  logic        flag;

  always #5 clk = ~clk;

  mor1kx_ctrl_except_cappuccino dut (
    .clk                      (clk),
    .rst                      (rst),
    .ctrl_advance_i           (advance),
    .ctrl_except_ibus_err_i   (ibus_err),
    .ctrl_except_ibus_align_i (ibus_align),
    .ctrl_except_illegal_i    (illegal),
    .ctrl_except_syscall_i    (syscall),
    .ctrl_except_trap_i       (trap),
    .ctrl_except_dbus_i       (dbus),
    .ctrl_except_align_i      (align),
    .ctrl_op_rfe_i            (rfe),
    .pc_ctrl_i                (pc_ctrl),
    .ctrl_alu_result_i        (alu_result),
    .ctrl_flag_set_i          (flag_set),
    .ctrl_flag_clear_i        (flag_clear),
    .spr_we_i                 (spr_we),
    .spr_addr_i               (spr_addr),
    .spr_dat_i                (spr_dat),
    .fetch_redirect_ack_i     (ack),
    .pipeline_flush_o         (pipeline_flush),
    .ctrl_stall_o             (ctrl_stall),
    .redirect_o               (redirect),
    .redirect_pc_o            (redirect_pc),
    .spr_sr_o                 (spr_sr),
    .spr_epcr_o               (spr_epcr),
    .spr_eear_o               (spr_eear),
    .spr_esr_o                (spr_esr),
    .flag_o                   (flag)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epcr;
    logic [31:0] eear;
    logic [15:0] esr;
    logic [15:0] sr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_insn();
    advance = 0;
    {ibus_err, ibus_align, illegal, syscall, trap, dbus, align} = 7'b0;
    rfe = 0; flag_set = 0; flag_clear = 0;
    spr_we = 0; spr_addr = 16'h0; spr_dat = 32'h0;
  endtask

  task automatic spr_write(input logic [15:0] addr, input logic [31:0] dat);
    spr_we = 1; spr_addr = addr; spr_dat = dat;
    tick();
    spr_we = 0;
    $display("txn spr_write addr=%h dat=%h", addr, dat);
  endtask

  // exc = {ibus_err, ibus_align, illegal, syscall, trap, dbus, align}
  task automatic run_event(input logic [6:0] exc, input logic is_rfe,
                           input logic [31:0] pc, input logic [31:0] alu,
                           input int hold, input logic noise, input logic collide);
    exp_t e;
    logic seen;
    {ibus_err, ibus_align, illegal, syscall, trap, dbus, align} = exc;
    rfe = is_rfe; pc_ctrl = pc; alu_result = alu; advance = 1;
    if (collide) begin
      spr_we = 1; spr_addr = 16'h0011; spr_dat = 32'h0;
    end
    tick();
    clear_insn();
    check("flush_pulse", pipeline_flush, 1'b1);
    check("stall_in_flush", ctrl_stall, 1'b1);
    check("no_redirect_in_flush", redirect, 1'b0);
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (redirect) seen = 1;
    end
    if (!seen) check("redirect_timeout", redirect, 1'b1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check("flush_dropped", pipeline_flush, 1'b0);
    check("redirect_pc", redirect_pc, e.pc);
    check("epcr", spr_epcr, e.epcr);
    check("eear", spr_eear, e.eear);
    check("esr", spr_esr, e.esr);
    check("sr", spr_sr, e.sr);
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        advance = 1; illegal = 1; flag_set = 1; pc_ctrl = 32'hDEAD0000;
      end
      tick();
      check("redirect_held", redirect, 1'b1);
      check("redirect_pc_stable", redirect_pc, e.pc);
    end
    clear_insn();
    ack = 1;
    tick();
    ack = 0;
    check("redirect_released", redirect, 1'b0);
    check("stall_released", ctrl_stall, 1'b0);
    n_txn++;
    $display("txn %0d event pc=%h target=%h sr=%h esr=%h epcr=%h eear=%h",
             n_txn, pc, redirect_pc, spr_sr, spr_esr, spr_epcr, spr_eear);
  endtask

  initial begin
    rst = 1; ack = 0; pc_ctrl = 0; alu_result = 0;
    clear_insn();
    repeat (3) tick();
    rst = 0;

    // Reset state
    check("rst_sr", spr_sr, 16'h8001);
    check("rst_epcr", spr_epcr, 32'h100);
    check("rst_eear", spr_eear, 32'h100);
    check("rst_esr", spr_esr, 16'h0);
    check("rst_flush", pipeline_flush, 1'b0);
    check("rst_stall", ctrl_stall, 1'b0);
    check("rst_redirect", redirect, 1'b0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_flag", flag, 1'b0);

    // SR write forces FO
    spr_write(16'h0011, 32'h0000_0007);
    check("sr_write_fo", spr_sr, 16'h8007);

    // Illegal, redirect held 3 cycles with ignored noise during WAIT
    sb.push_back('{pc: 32'h700, epcr: 32'h2000, eear: 32'h2000, esr: 16'h8007, sr: 16'h8001});
    run_event(7'b0010000, 1'b0, 32'h2000, 32'h0, 3, 1'b1, 1'b0);
    tick();
    check("no_event_from_noise", pipeline_flush, 1'b0);
    check("flag_noise_ignored", flag, 1'b0);

    // Syscall + dbus: syscall wins, earliest possible ack
    sb.push_back('{pc: 32'hC00, epcr: 32'h3004, eear: 32'h3000, esr: 16'h8001, sr: 16'h8001});
    run_event(7'b0001010, 1'b0, 32'h3000, 32'h9999, 0, 1'b0, 1'b0);

    // Alignment on a load saves the effective address
    sb.push_back('{pc: 32'h600, epcr: 32'h4000, eear: 32'h5003, esr: 16'h8001, sr: 16'h8001});
    run_event(7'b0000001, 1'b0, 32'h4000, 32'h5003, 1, 1'b0, 1'b0);

    // RFE
    spr_write(16'h0040, 32'hFFFF_0204);
    check("esr_write_trunc", spr_esr, 16'h0204);
    spr_write(16'h0020, 32'h0000_1234);
    check("epcr_write", spr_epcr, 32'h1234);
    sb.push_back('{pc: 32'h1234, epcr: 32'h1234, eear: 32'h5003, esr: 16'h0204, sr: 16'h8204});
    run_event(7'b0000000, 1'b1, 32'h8888, 32'h0, 0, 1'b0, 1'b0);
    check("rfe_flag", flag, 1'b1);

    // Flag requests
    advance = 1; flag_clear = 1;
    tick(); clear_insn();
    check("flag_clear", flag, 1'b0);
    advance = 1; flag_set = 1; flag_clear = 1;
    tick(); clear_insn();
    check("flag_set_wins", flag, 1'b1);
    flag_clear = 1;
    tick(); clear_insn();
    check("flag_needs_advance", flag, 1'b1);

    // Unmapped SPR address is ignored
    spr_write(16'h0050, 32'h0);
    check("unmapped_sr", spr_sr, 16'h8204);
    check("unmapped_eear", spr_eear, 32'h5003);

    // Trap with a colliding SR write: the event wins
    sb.push_back('{pc: 32'hE00, epcr: 32'h6000, eear: 32'h6000, esr: 16'h8204, sr: 16'h8201});
    run_event(7'b0000100, 1'b0, 32'h6000, 32'h0, 0, 1'b0, 1'b1);
    spr_write(16'h0011, 32'h0);
    check("sr_write_zero", spr_sr, 16'h8000);
    check("sr_write_zero_flag", flag, 1'b0);
    spr_write(16'h0030, 32'hABCD_0000);
    check("eear_write", spr_eear, 32'hABCD_0000);

    // Reset while waiting for the redirect ack
    ibus_err = 1; advance = 1; pc_ctrl = 32'h7000;
    tick(); clear_insn();
    tick();
    check("wait_redirect", redirect, 1'b1);
    check("wait_redirect_pc", redirect_pc, 32'h200);
    rst = 1;
    tick();
    rst = 0;
    check("rst_wait_redirect", redirect, 1'b0);
    check("rst_wait_stall", ctrl_stall, 1'b0);
    check("rst_wait_flush", pipeline_flush, 1'b0);
    check("rst_wait_redirect_pc", redirect_pc, 32'h0);
    check("rst_wait_sr", spr_sr, 16'h8001);
    check("rst_wait_epcr", spr_epcr, 32'h100);
    tick();
    check("rst_wait_stays_run", redirect, 1'b0);
    $display("txn reset_in_wait redirect=%b stall=%b", redirect, ctrl_stall);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
